// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a three-state data-cache request sequencer.
// Optional macro EX_MEM_TRACKER_EN adds instruction/PC tracker registers.
//
// state | meaning
// IDLE  | no memory access pending; stage may capture or bubble
// REQ   | data-cache request outstanding; stage frozen until dhit
// DONE  | request completed last cycle; stage may capture again

module ex_mem_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        enable_EX_MEM,
    input  logic        flush_EX_MEM,
    input  logic        dREN_ID_EX,
    input  logic        dWEN_ID_EX,
    input  logic        WEN_ID_EX,
    input  logic        halt_ID_EX,
    input  logic [4:0]  wsel_EX,
    input  logic [31:0] alu_out_EX,
    input  logic [31:0] store_data_EX,
    input  logic        dhit,
    input  logic [31:0] dmemload,
`ifdef EX_MEM_TRACKER_EN
    input  logic [31:0] instruction_ID_EX,
    input  logic [31:0] imemaddr_ID_EX,
    input  logic [31:0] next_imemaddr_ID_EX,
    output logic [31:0] instruction_EX_MEM,
    output logic [31:0] imemaddr_EX_MEM,
    output logic [31:0] next_imemaddr_EX_MEM,
`endif
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        WEN_EX_MEM,
    output logic        halt_EX_MEM,
    output logic [4:0]  wsel_EX_MEM,
    output logic [31:0] alu_out_EX_MEM,
    output logic [31:0] dload_EX_MEM,
    output logic        mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, next_state;

    logic        dren_q;
    logic        dwen_q;
    logic [31:0] store_data_q;

    logic        can_capture;
    logic        load_bubble;
    logic        load_inputs;
    logic        take_load;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        can_capture = (state != REQ);
        load_bubble = can_capture && flush_EX_MEM;
        load_inputs = can_capture && !flush_EX_MEM && enable_EX_MEM;
        take_load   = (state == REQ) && dhit;

        next_state  = IDLE;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        mem_stall   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (load_inputs && (dREN_ID_EX || dWEN_ID_EX)) begin
                    next_state = REQ;
                end else begin
                    next_state = IDLE;
                end
            end
            REQ: begin
                // a store that also has dREN latched is issued as a store only
                dWEN      = dwen_q;
                dREN      = dren_q && !dwen_q;
                mem_stall = !dhit;
                next_state = dhit ? DONE : REQ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            dren_q         <= 1'b0;
            dwen_q         <= 1'b0;
            WEN_EX_MEM     <= 1'b0;
            halt_EX_MEM    <= 1'b0;
            wsel_EX_MEM    <= 5'd0;
            alu_out_EX_MEM <= 32'd0;
            store_data_q   <= 32'd0;
            dload_EX_MEM   <= 32'd0;
        end else if (load_bubble) begin
            dren_q         <= 1'b0;
            dwen_q         <= 1'b0;
            WEN_EX_MEM     <= 1'b0;
            halt_EX_MEM    <= 1'b0;
            wsel_EX_MEM    <= 5'd0;
            alu_out_EX_MEM <= 32'd0;
            store_data_q   <= 32'd0;
            dload_EX_MEM   <= 32'd0;
        end else if (load_inputs) begin
            // dload_EX_MEM keeps the last returned data across a normal capture
            dren_q         <= dREN_ID_EX;
            dwen_q         <= dWEN_ID_EX;
            WEN_EX_MEM     <= WEN_ID_EX;
            halt_EX_MEM    <= halt_ID_EX;
            wsel_EX_MEM    <= wsel_EX;
            alu_out_EX_MEM <= alu_out_EX;
            store_data_q   <= store_data_EX;
        end else if (take_load) begin
            dload_EX_MEM   <= dmemload;
        end
    end

`ifdef EX_MEM_TRACKER_EN
    always_ff @(posedge CLK) begin
        if (!nRST || load_bubble) begin
            instruction_EX_MEM   <= 32'd0;
            imemaddr_EX_MEM      <= 32'd0;
            next_imemaddr_EX_MEM <= 32'd0;
        end else if (load_inputs) begin
            instruction_EX_MEM   <= instruction_ID_EX;
            imemaddr_EX_MEM      <= imemaddr_ID_EX;
            next_imemaddr_EX_MEM <= next_imemaddr_ID_EX;
        end
    end
`endif

    assign dmemaddr  = alu_out_EX_MEM;
    assign dmemstore = store_data_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg: reset, ALU pass-through,
// load/store handshakes, flush priority and reset during an outstanding request.

module tb_ex_mem_reg;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        enable_EX_MEM, flush_EX_MEM;
    logic        dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX;
    logic [4:0]  wsel_EX;
    logic [31:0] alu_out_EX, store_data_EX;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dREN, dWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        WEN_EX_MEM, halt_EX_MEM;
    logic [4:0]  wsel_EX_MEM;
    logic [31:0] alu_out_EX_MEM, dload_EX_MEM;
    logic        mem_stall;
`ifdef EX_MEM_TRACKER_EN
    logic [31:0] instruction_ID_EX, imemaddr_ID_EX, next_imemaddr_ID_EX;
    logic [31:0] instruction_EX_MEM, imemaddr_EX_MEM, next_imemaddr_EX_MEM;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ex_mem_reg dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .enable_EX_MEM  (enable_EX_MEM),
        .flush_EX_MEM   (flush_EX_MEM),
        .dREN_ID_EX     (dREN_ID_EX),
        .dWEN_ID_EX     (dWEN_ID_EX),
        .WEN_ID_EX      (WEN_ID_EX),
        .halt_ID_EX     (halt_ID_EX),
        .wsel_EX        (wsel_EX),
        .alu_out_EX     (alu_out_EX),
        .store_data_EX  (store_data_EX),
        .dhit           (dhit),
        .dmemload       (dmemload),
`ifdef EX_MEM_TRACKER_EN
        .instruction_ID_EX    (instruction_ID_EX),
        .imemaddr_ID_EX       (imemaddr_ID_EX),
        .next_imemaddr_ID_EX  (next_imemaddr_ID_EX),
        .instruction_EX_MEM   (instruction_EX_MEM),
        .imemaddr_EX_MEM      (imemaddr_EX_MEM),
        .next_imemaddr_EX_MEM (next_imemaddr_EX_MEM),
`endif
        .dREN           (dREN),
        .dWEN           (dWEN),
        .dmemaddr       (dmemaddr),
        .dmemstore      (dmemstore),
        .WEN_EX_MEM     (WEN_EX_MEM),
        .halt_EX_MEM    (halt_EX_MEM),
        .wsel_EX_MEM    (wsel_EX_MEM),
        .alu_out_EX_MEM (alu_out_EX_MEM),
        .dload_EX_MEM   (dload_EX_MEM),
        .mem_stall      (mem_stall)
    );

    // ctl = {enable, flush, dREN, dWEN, WEN, halt}
    // xctl = expected {dREN, dWEN, mem_stall, WEN_EX_MEM, halt_EX_MEM}
    typedef struct {
        logic [5:0]  ctl;
        logic [4:0]  ws;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        dh;
        logic [31:0] dml;
        logic [4:0]  xctl;
        logic [4:0]  xws;
        logic [31:0] xalu;
        logic [31:0] xsd;
        logic [31:0] xdload;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [4:0] ws,
                                input logic [31:0] alu, input logic [31:0] sd,
                                input logic dh, input logic [31:0] dml,
                                input logic [4:0] xctl, input logic [4:0] xws,
                                input logic [31:0] xalu, input logic [31:0] xsd,
                                input logic [31:0] xdload);
        vec_t v;
        v.ctl = ctl; v.ws = ws; v.alu = alu; v.sd = sd; v.dh = dh; v.dml = dml;
        v.xctl = xctl; v.xws = xws; v.xalu = xalu; v.xsd = xsd; v.xdload = xdload;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [4:0] ws, input logic [31:0] alu,
                         input logic [31:0] sd, input logic dh, input logic [31:0] dml);
        {enable_EX_MEM, flush_EX_MEM, dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX} = ctl;
        wsel_EX = ws; alu_out_EX = alu; store_data_EX = sd; dhit = dh; dmemload = dml;
`ifdef EX_MEM_TRACKER_EN
        instruction_ID_EX = alu ^ 32'h5A5A_0000;
        imemaddr_ID_EX = alu + 32'd4;
        next_imemaddr_ID_EX = alu + 32'd8;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dREN"}, {31'd0, dREN}, 32'd0);
        chk({tag, "_dWEN"}, {31'd0, dWEN}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        chk({tag, "_WEN"}, {31'd0, WEN_EX_MEM}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halt_EX_MEM}, 32'd0);
        chk({tag, "_wsel"}, {27'd0, wsel_EX_MEM}, 32'd0);
        chk({tag, "_alu"}, alu_out_EX_MEM, 32'd0);
        chk({tag, "_addr"}, dmemaddr, 32'd0);
        chk({tag, "_store"}, dmemstore, 32'd0);
        chk({tag, "_dload"}, dload_EX_MEM, 32'd0);
    endtask

    initial begin
        // steady-state ALU op, load with 3 wait cycles, store with enable/flush
        // toggled while pending, dREN+dWEN conflict, flush priority, non-sticky halt
        vecs.push_back(mk(6'b100010, 5'd3, 32'h10, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00010, 5'd3, 32'h10, 32'h0, 32'h0));
        vecs.push_back(mk(6'b101010, 5'd5, 32'h40, 32'h0, 1'b0, 32'h0, 5'b00010, 5'd3, 32'h10, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b10110, 5'd5, 32'h40, 32'h0, 32'h0));
        vecs.push_back(mk(6'b110000, 5'd0, 32'h99, 32'h0, 1'b0, 32'h0, 5'b10110, 5'd5, 32'h40, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b10110, 5'd5, 32'h40, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 5'b10010, 5'd5, 32'h40, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00010, 5'd5, 32'h40, 32'h0, 32'hDEADBEEF));
        vecs.push_back(mk(6'b100100, 5'd0, 32'h80, 32'hCAFE0001, 1'b0, 32'h0, 5'b00010, 5'd5, 32'h40, 32'h0, 32'hDEADBEEF));
        vecs.push_back(mk(6'b100000, 5'd0, 32'h1234, 32'h0, 1'b0, 32'h0, 5'b01100, 5'd0, 32'h80, 32'hCAFE0001, 32'hDEADBEEF));
        vecs.push_back(mk(6'b010000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b01100, 5'd0, 32'h80, 32'hCAFE0001, 32'hDEADBEEF));
        vecs.push_back(mk(6'b110000, 5'd0, 32'h0, 32'h0, 1'b1, 32'h11111111, 5'b01000, 5'd0, 32'h80, 32'hCAFE0001, 32'hDEADBEEF));
        vecs.push_back(mk(6'b101111, 5'd7, 32'hC0, 32'h55, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h80, 32'hCAFE0001, 32'h11111111));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b01111, 5'd7, 32'hC0, 32'h55, 32'h11111111));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b1, 32'hAAAA, 5'b01011, 5'd7, 32'hC0, 32'h55, 32'h11111111));
        vecs.push_back(mk(6'b111000, 5'd0, 32'h44, 32'h0, 1'b0, 32'h0, 5'b00011, 5'd7, 32'hC0, 32'h55, 32'hAAAA));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b111000, 5'd0, 32'h44, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b100001, 5'd0, 32'h8, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b100000, 5'd0, 32'h9, 32'h0, 1'b0, 32'h0, 5'b00001, 5'd0, 32'h8, 32'h0, 32'h0));
        vecs.push_back(mk(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00000, 5'd0, 32'h9, 32'h0, 32'h0));

        // reset held for two edges with random inputs
        nRST = 1'b0;
        drive(6'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
        @(posedge CLK);
        drive(6'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
        @(posedge CLK);
        @(negedge CLK);
        drive(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk_all_zero("reset");
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].ctl, vecs[i].ws, vecs[i].alu, vecs[i].sd, vecs[i].dh, vecs[i].dml);
            #1;
            chk($sformatf("v%0d_dREN", i), {31'd0, dREN}, {31'd0, vecs[i].xctl[4]});
            chk($sformatf("v%0d_dWEN", i), {31'd0, dWEN}, {31'd0, vecs[i].xctl[3]});
            chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, {31'd0, vecs[i].xctl[2]});
            chk($sformatf("v%0d_WEN", i), {31'd0, WEN_EX_MEM}, {31'd0, vecs[i].xctl[1]});
            chk($sformatf("v%0d_halt", i), {31'd0, halt_EX_MEM}, {31'd0, vecs[i].xctl[0]});
            chk($sformatf("v%0d_wsel", i), {27'd0, wsel_EX_MEM}, {27'd0, vecs[i].xws});
            chk($sformatf("v%0d_alu", i), alu_out_EX_MEM, vecs[i].xalu);
            chk($sformatf("v%0d_addr", i), dmemaddr, vecs[i].xalu);
            chk($sformatf("v%0d_store", i), dmemstore, vecs[i].xsd);
            chk($sformatf("v%0d_dload", i), dload_EX_MEM, vecs[i].xdload);
        end

        // reset while a store+load request is outstanding
        @(negedge CLK);
        drive(6'b101110, 5'd9, 32'h70, 32'h77, 1'b0, 32'h0);
        @(negedge CLK);
        drive(6'b000000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("midreq_dWEN", {31'd0, dWEN}, 32'd1);
        chk("midreq_stall", {31'd0, mem_stall}, 32'd1);
        chk("midreq_addr", dmemaddr, 32'h70);
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        chk_all_zero("abort");
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_abort_dWEN", {31'd0, dWEN}, 32'd0);
        chk("post_abort_stall", {31'd0, mem_stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
